spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter RD_WAIT, default 2, meaning the number of turnaround cycles between the last MOSI bit of a read-data frame and the first MISO sample.
REQ-002 The block SHALL have parameter DW, default 8, meaning the payload and read-data width; the frame body is always DW+2 bits.
REQ-003 clk  input  1  single system clock, also the SPI bit clock shared with the slave; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse; accepted only in IDLE.
REQ-006 cmd  input  2  frame command: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-007 payload  input  DW  address or data byte sent after cmd.
REQ-008 busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-009 done  output  1  one-cycle pulse at frame end.
REQ-010 rd_data  output  DW  byte received on MISO, held until the next read-data frame completes.
REQ-011 rd_valid  output  1  one-cycle pulse, coincident with done, only for cmd=11.
REQ-012 SS_n  output  1  active-low slave select.
REQ-013 MOSI  output  1  serial data to the slave.
REQ-014 MISO  input  1  serial data from the slave.

Function
REQ-015 SS_n, MOSI, busy, done, rd_data and rd_valid SHALL all be registered outputs.
REQ-016 The FSM SHALL have the states IDLE, START, CMD, SHIFT, HOLD, WAIT, READ and STOP.
REQ-017 IDLE: SS_n=1, MOSI=0; start=1 at an edge SHALL latch cmd and payload into a DW+2-bit shift register {cmd,payload} and move the FSM to START.
REQ-018 START (1 cycle): SS_n=0, MOSI=0; this gives the slave one cycle to leave its own idle state.
REQ-019 CMD (1 cycle): SS_n=0, MOSI=cmd[1], the slave's command-select bit.
REQ-020 SHIFT (DW+2 cycles): MOSI SHALL be the shift register MSB, shifted left one bit per cycle, so that cmd[1], cmd[0], payload[DW-1]..payload[0] go out MSB first.
REQ-021 HOLD (1 cycle): SS_n=0, MOSI=0; this lets the slave assert its rx_valid. From HOLD, the FSM SHALL go to WAIT if the latched cmd=11, otherwise to STOP.
REQ-022 WAIT (RD_WAIT cycles): SS_n=0, MOSI=0, MISO ignored; RD_WAIT=0 SHALL skip WAIT and go straight to READ.
REQ-023 READ (DW cycles): SS_n=0, MOSI=0; at each edge, MISO SHALL be shifted into the receive register LSB-side, so the first sample ends up in rd_data[DW-1].
REQ-024 STOP (1 cycle): SS_n=1, done=1; for cmd=11, rd_data SHALL be updated from the receive register and rd_valid=1 in the same cycle. STOP then goes to IDLE.
REQ-025 SS_n low duration SHALL be exactly DW+5 cycles for cmd≠11 and DW+5+RD_WAIT+DW cycles for cmd=11.
REQ-026 Between frames, SS_n SHALL stay high for at least 2 cycles (STOP plus IDLE).
REQ-027 A start outside IDLE, including during STOP, SHALL be ignored with no queuing.
REQ-028 Changes on cmd or payload after acceptance SHALL NOT affect the frame in progress.
REQ-029 Bit and cycle counters SHALL be wide enough for max(DW+2, RD_WAIT, DW) and SHALL be cleared on every state entry; there is no wrap within a state.
REQ-030 rd_data SHALL NOT change on frames with cmd≠11.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, and clear all counters and shift registers.
REQ-032 Reset mid-frame SHALL abort the frame with no done or rd_valid pulse; after release, the block SHALL accept a new start normally.
REQ-033 Each output SHALL resume its registered behaviour from the first rising edge after rst_n deasserts.

Verification
REQ-034 Write-address: cmd=00, payload=0xA5 -> SS_n low 13 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1,0 (START, CMD, 10-bit body, HOLD); done pulses once; rd_valid stays 0.
REQ-035 Read-data, default RD_WAIT, MISO model returns 0x3C starting at READ -> SS_n low 23 cycles; rd_data=0x3C; rd_valid and done high in the same single cycle.
REQ-036 Back-to-back: start held high continuously through a frame -> the second frame begins only after IDLE; SS_n high for exactly 2 cycles between frames.
REQ-037 start pulsed during SHIFT with different cmd/payload -> ignored; the current frame's MOSI bits are unchanged.
REQ-038 rst_n asserted during READ of a cmd=11 frame -> SS_n=1 asynchronously; rd_data=0; no done pulse; the next cmd=11 frame completes correctly.
REQ-039 A loopback with the team's SPI slave and RAM (write address 0x12, write data 0x77, read address 0x12, read data) -> rd_data=0x77.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: sends a {cmd, payload} frame MSB first and, for read-data frames,
// captures DW bits from MISO after RD_WAIT turnaround cycles.
module spi_master #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned DW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    cmd,
    input  logic [DW-1:0] payload,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          SS_n,
    output logic          MOSI,
    input  logic          MISO
);

    localparam int unsigned FW   = DW + 2;
    localparam int unsigned MAXC = (FW > RD_WAIT) ? FW : RD_WAIT;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ShiftLast = CW'(FW - 1);
    localparam logic [CW-1:0] WaitLast  = CW'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
    localparam logic [CW-1:0] ReadLast  = CW'(DW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StCmd,
        StShift,
        StHold,
        StWait,
        StRead,
        StStop
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] sr_q, sr_d;
    logic [DW-1:0] rx_q, rx_d;
    logic          rd_q, rd_d;

    logic          ss_n_d;
    logic          mosi_d;
    logic          busy_d;
    logic          done_d;
    logic          rd_valid_d;
    logic [DW-1:0] rd_data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sr_d    = sr_q;
        rx_d    = rx_q;
        rd_d    = rd_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    sr_d    = {cmd, payload};
                    rd_d    = (cmd == 2'b11);
                    state_d = StStart;
                end
            end
            StStart: state_d = StCmd;
            StCmd:   state_d = StShift;
            StShift: begin
                if (cnt_q == ShiftLast) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!rd_q) begin
                    state_d = StStop;
                end else if (RD_WAIT == 0) begin
                    state_d = StRead;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                rx_d = (rx_q << 1) | {{(DW-1){1'b0}}, MISO};
                if (cnt_q == ReadLast) begin
                    state_d = StStop;
                end
            end
            StStop:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are registered, so they are derived from the state being entered.
        mosi_d = 1'b0;
        if (state_d == StCmd) begin
            mosi_d = sr_q[FW-1];
        end else if (state_d == StShift) begin
            mosi_d = sr_q[FW-1];
            sr_d   = sr_q << 1;
        end

        ss_n_d     = (state_d == StIdle) || (state_d == StStop);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StStop);
        rd_valid_d = (state_d == StStop) && rd_q;
        rd_data_d  = rd_valid_d ? rx_d : rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sr_q     <= '0;
            rx_q     <= '0;
            rd_q     <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            rx_q     <= rx_d;
            rd_q     <= rd_d;
            SS_n     <= ss_n_d;
            MOSI     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a small behavioural slave + RAM on the SPI pins.
module tb_spi_master;

    localparam int unsigned RD_WAIT = 2;
    localparam int unsigned DW      = 8;
    localparam int          READ0   = 13 + RD_WAIT;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    cmd;
    logic [DW-1:0] payload;
    logic          busy;
    logic          done;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;

    spi_master #(
        .RD_WAIT(RD_WAIT),
        .DW     (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd     (cmd),
        .payload (payload),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave/RAM model and bus monitor, all sampled on the falling edge.
    logic [7:0]  mem [256];
    logic [7:0]  addr_m;
    logic [7:0]  raddr_m;
    logic [63:0] mosi_vec;
    logic [63:0] body;
    logic [7:0]  rbyte;
    logic [1:0]  frame_cmd;
    int          low_cnt   = 0;
    int          high_cnt  = 0;
    int          last_low  = 0;
    int          last_high = 0;
    int          done_cnt  = 0;
    int          rdv_cnt   = 0;
    int          split_cnt = 0;

    always @(negedge clk) begin
        if (!SS_n) begin
            if (low_cnt == 0) begin
                last_high = high_cnt;
                frame_cmd = 2'b00;
                mosi_vec  = '0;
            end
            high_cnt = 0;
            mosi_vec = {mosi_vec[62:0], MOSI};
            if (low_cnt == 3) frame_cmd = mosi_vec[1:0];
            rbyte = mem[raddr_m];
            if (frame_cmd == 2'b11 && low_cnt >= READ0 && low_cnt < READ0 + 8)
                MISO = rbyte[7 - (low_cnt - READ0)];
            else
                MISO = 1'b0;
            low_cnt++;
        end else begin
            if (low_cnt != 0) begin
                last_low = low_cnt;
                if (low_cnt >= 13) begin
                    body = mosi_vec >> (low_cnt - 13);
                    case (body[10:9])
                        2'b00:   addr_m = body[8:1];
                        2'b01:   mem[addr_m] = body[8:1];
                        2'b10:   raddr_m = body[8:1];
                        default: ;
                    endcase
                end
            end
            low_cnt = 0;
            high_cnt++;
            MISO = 1'b0;
        end
        if (done) done_cnt++;
        if (rd_valid) rdv_cnt++;
        if (rd_valid && !done) split_cnt++;
    end

    int d_base;
    int r_base;
    int s_base;

    task automatic send(input logic [1:0] c, input logic [7:0] p, input bit inject);
        @(negedge clk);
        cmd    = c;
        payload = p;
        start  = 1'b1;
        d_base = done_cnt;
        r_base = rdv_cnt;
        s_base = split_cnt;
        @(negedge clk);
        start   = 1'b0;
        cmd     = ~c;
        payload = ~p;
        check("busy_after_accept", 32'(busy), 32'd1);
        if (inject) begin
            repeat (4) @(negedge clk);
            cmd     = 2'b11;
            payload = 8'hFF;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 80 && done_cnt == d_base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d_base), 32'd1);
        check("idle_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]  = 8'h3C;
        addr_m  = 8'h00;
        raddr_m = 8'h00;
        MISO    = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        cmd     = 2'b00;
        payload = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write address 0xA5
        send(2'b00, 8'hA5, 1'b0);
        check("wa_ss_low", 32'(last_low), 32'd13);
        check("wa_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_0_00_10100101_0));
        check("wa_rd_valid", 32'(rdv_cnt - r_base), 32'd0);
        check("wa_rd_data", 32'(rd_data), 32'h00);

        // Write data 0x5A
        send(2'b01, 8'h5A, 1'b0);
        check("wd_ss_low", 32'(last_low), 32'd13);
        check("wd_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_0_01_01011010_0));
        check("wd_rd_data", 32'(rd_data), 32'h00);

        // Read data: slave returns mem[0] = 0x3C
        send(2'b11, 8'h00, 1'b0);
        check("rd_ss_low", 32'(last_low), 32'd23);
        check("rd_mosi", 32'(mosi_vec[22:0]), 32'(23'b0_1_11_00000000_0_0000000000));
        check("rd_data", 32'(rd_data), 32'h3C);
        check("rd_valid_pulses", 32'(rdv_cnt - r_base), 32'd1);
        check("rd_valid_with_done", 32'(split_cnt - s_base), 32'd0);

        // Back-to-back with start held high
        d_base = done_cnt;
        @(negedge clk);
        cmd     = 2'b00;
        payload = 8'h3C;
        start   = 1'b1;
        for (int i = 0; i < 100 && done_cnt < d_base + 2; i++) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_frames", 32'(done_cnt - d_base), 32'd2);
        check("b2b_ss_gap", 32'(last_high), 32'd2);
        check("b2b_ss_low", 32'(last_low), 32'd13);
        check("b2b_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_0_00_00111100_0));
        check("b2b_idle", 32'(busy), 32'd0);
        check("b2b_rd_data", 32'(rd_data), 32'h3C);

        // Start pulsed mid-SHIFT with other cmd/payload must be ignored
        send(2'b10, 8'h81, 1'b1);
        check("inj_ss_low", 32'(last_low), 32'd13);
        check("inj_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_1_10_10000001_0));
        check("inj_rd_valid", 32'(rdv_cnt - r_base), 32'd0);

        // Reset in the middle of READ
        @(negedge clk);
        cmd     = 2'b11;
        payload = 8'h00;
        start   = 1'b1;
        d_base  = done_cnt;
        r_base  = rdv_cnt;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && low_cnt < 18; i++) @(negedge clk);
        check("abort_in_read", 32'(low_cnt >= 18), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ss_n", 32'(SS_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_data", 32'(rd_data), 32'h00);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d_base), 32'd0);
        check("abort_no_rd_valid", 32'(rdv_cnt - r_base), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback through the slave RAM
        send(2'b00, 8'h12, 1'b0);
        check("lb_wa_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_0_00_00010010_0));
        send(2'b01, 8'h77, 1'b0);
        check("lb_wd_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_0_01_01110111_0));
        send(2'b10, 8'h12, 1'b0);
        check("lb_ra_mosi", 32'(mosi_vec[12:0]), 32'(13'b0_1_10_00010010_0));
        send(2'b11, 8'h00, 1'b0);
        check("lb_ss_low", 32'(last_low), 32'd23);
        check("lb_rd_data", 32'(rd_data), 32'h77);
        check("lb_rd_valid", 32'(rdv_cnt - r_base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
